gpio_input_capture: RTL

GPIO_INPUT_CAPTURE -- requirements
Module: gpio_input_capture

---
 rtl/gpio_input_pkg.sv | 8 +
 rtl/gpio_debounce_bit.sv | 61 ++++++
 rtl/gpio_input_capture.sv | 56 +++++
 3 files changed

// File: rtl/gpio_input_pkg.sv
// gpio_input_pkg: shared defaults, debounce state type and arm length for gpio_input_capture
// Contents: DEFAULT_WIDTH, DEFAULT_DEBOUNCE_CYCLES, ARM_CYCLES, db_state_e (STABLE, COUNTING).
package gpio_input_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 3000;
  localparam int ARM_CYCLES = 3;
  typedef enum logic {STABLE, COUNTING} db_state_e;
endpackage

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit: 2-flop synchronizer plus debounce FSM for one GPIO pin
// Ports: clk, reset (async, active-high), pin (raw input), load (end of arm phase:
//   take synchronized value with no edge), run (armed, normal operation),
//   state (debounced level), rise/fall (one-cycle registered edge events).
// Macro GPIO_INPUT_DEBOUNCE_EN: defined -> counting debounce; undefined -> state follows sync2.
module gpio_debounce_bit
  import gpio_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  input  logic load,
  input  logic run,
  output logic state,
  output logic rise,
  output logic fall
);
  logic s1, s2;
`ifdef GPIO_INPUT_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  db_state_e fsm;
  logic [CW-1:0] count;
  logic [CW:0] next;
  logic diff, flip;
  assign diff = run && (s2 != state);
  assign next = fsm == COUNTING ? {1'b0, count} + (CW+1)'(1) : (CW+1)'(1);
  // the cycle the count would reach the window length ends the debounce
  assign flip = diff && next == (CW+1)'(DEBOUNCE_CYCLES);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {s2, s1} <= '0;
      fsm <= STABLE;
      count <= '0;
      state <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      {s2, s1} <= {s1, pin};
      state <= load || flip ? s2 : state;
      rise <= flip && s2;
      fall <= flip && !s2;
      fsm <= diff && !flip ? COUNTING : STABLE;
      count <= diff && !flip ? next[CW-1:0] : '0;
    end
`else
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {s2, s1} <= '0;
      state <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      {s2, s1} <= {s1, pin};
      state <= load || run ? s2 : state;
      rise <= run && s2 && !state;
      fall <= run && !s2 && state;
    end
`endif
endmodule

// File: rtl/gpio_input_capture.sv
// gpio_input_capture: debounced GPIO inputs with sticky edge flags and level interrupt
// Ports: clk, reset (async, active-high), gpio_io_i (raw pins), rise_en/fall_en (irq enables),
//   clr_valid/clr_mask (pending clear strobe), gpio_state (debounced level),
//   rise_pending/fall_pending (sticky edge flags), irq (registered interrupt).
// Macro GPIO_INPUT_DEBOUNCE_EN enables the per-bit debounce counters.
module gpio_input_capture
  import gpio_input_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gpio_io_i,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic             clr_valid,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] gpio_state,
  output logic [WIDTH-1:0] rise_pending,
  output logic [WIDTH-1:0] fall_pending,
  output logic             irq
);
  logic [1:0] arm_cnt;
  logic load, run;
  logic [WIDTH-1:0] rise, fall, clr;
  // arm phase lets the synchronizers fill before gpio_state is seeded
  assign load = arm_cnt == 2'(ARM_CYCLES - 1);
  assign run = arm_cnt == 2'(ARM_CYCLES);
  assign clr = clr_valid ? clr_mask : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      arm_cnt <= '0;
      rise_pending <= '0;
      fall_pending <= '0;
      irq <= 1'b0;
    end else begin
      arm_cnt <= run ? arm_cnt : arm_cnt + 2'd1;
      // a new edge overrides a simultaneous clear
      rise_pending <= (rise_pending & ~clr) | rise;
      fall_pending <= (fall_pending & ~clr) | fall;
      irq <= |((rise_pending & rise_en) | (fall_pending & fall_en));
    end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
      .clk(clk),
      .reset(reset),
      .pin(gpio_io_i[i]),
      .load(load),
      .run(run),
      .state(gpio_state[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end
endmodule
